// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing defaults, field widths and addr layout shared by the scanner files.
// Pure constants and a helper; no logic, no latency, no flow control.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int COLOR_W = 3;
  localparam int CNT_W   = 10;
  localparam int ADDR_W  = 20;
  localparam int X_LSB   = 9;
  localparam int Y_LSB   = 0;
  localparam int Y_W     = X_LSB - Y_LSB;

  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_scanner_if.sv
// Pixel-memory read port plus DAC/sync outputs of the scanner.
// Master = scanner (drives addr and DAC side); slave = memory/board side.
interface vga_scanner_if;
  import vga_timing_pkg::*;

  logic [ADDR_W-1:0]  addr;
  logic [COLOR_W-1:0] ired;
  logic [COLOR_W-1:0] igreen;
  logic [COLOR_W-1:0] iblue;
  logic [COLOR_W-1:0] ored;
  logic [COLOR_W-1:0] ogreen;
  logic [COLOR_W-1:0] oblue;
  logic               hs;
  logic               vs;
  logic               frame_start;

  modport master (
    output addr, ored, ogreen, oblue, hs, vs, frame_start,
    input  ired, igreen, iblue
  );

  modport slave (
    input  addr, ored, ogreen, oblue, hs, vs, frame_start,
    output ired, igreen, iblue
  );

endinterface

// File: rtl/vga_pixel_counter.sv
// Pixel-rate divider and h/v raster counters; active and frame_wrap decode same-cycle.
// Free-running, no backpressure.
module vga_pixel_counter
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_TOTAL  = DEF_V_TOTAL
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pe,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             frame_wrap
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);

  logic line_end;

  generate
    if (CLK_DIV == 1) begin : g_nodiv
      assign pe = 1'b1;
    end else begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
      logic [DW-1:0] div_cnt;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      assign pe = (div_cnt == DIV_LAST);
    end
  endgenerate

  assign line_end = (h_cnt == H_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pe) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign frame_wrap = pe && line_end && (v_cnt == V_LAST);

endmodule

// File: rtl/vga_scanner.sv
// VGA raster scanner: addr decoded from counters, colour/hs/vs registered one pixel later
// on pe; free-running, no backpressure. VGA_SCANNER_BORDER_EN forces a white frame border.
module vga_scanner
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic          clk,
  input  logic          rst,
  vga_scanner_if.master bus
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic                   pe;
  logic [CNT_W-1:0]       h_cnt;
  logic [CNT_W-1:0]       v_cnt;
  logic                   active;
  logic                   frame_wrap;
  logic                   border;
  logic [ADDR_W-1:0]      addr_d;
  logic [3*COLOR_W-1:0]   pix_d;
  logic [3*COLOR_W-1:0]   pix_q;
  logic                   hs_q;
  logic                   vs_q;

  vga_pixel_counter #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .pe         (pe),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .active     (active),
    .frame_wrap (frame_wrap)
  );

`ifdef VGA_SCANNER_BORDER_EN
  assign border = (h_cnt == '0) || (h_cnt == CNT_W'(H_ACTIVE - 1)) ||
                  (v_cnt == '0) || (v_cnt == CNT_W'(V_ACTIVE - 1));
`else
  assign border = 1'b0;
`endif

  // Blanked pixels read as address 0 so the memory never sees out-of-range coordinates.
  always_comb begin
    addr_d = '0;
    pix_d  = '0;
    if (active) begin
      addr_d[X_LSB +: CNT_W] = h_cnt;
      addr_d[Y_LSB +: Y_W]   = v_cnt[Y_W-1:0];
      pix_d = border ? '1 : {bus.ired, bus.igreen, bus.iblue};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (pe) begin
      pix_q <= pix_d;
      hs_q  <= ~((h_cnt >= HS_START) && (h_cnt < HS_END));
      vs_q  <= ~((v_cnt >= VS_START) && (v_cnt < VS_END));
    end
  end

  assign bus.addr        = addr_d;
  assign bus.ored        = pix_q[3*COLOR_W-1 -: COLOR_W];
  assign bus.ogreen      = pix_q[2*COLOR_W-1 -: COLOR_W];
  assign bus.oblue       = pix_q[COLOR_W-1:0];
  assign bus.hs          = hs_q;
  assign bus.vs          = vs_q;
  assign bus.frame_start = frame_wrap;

endmodule

// File: doc/vga_scanner.md
Name: vga_scanner

Overview:
- Reader side of the sprite graphics memory's pixel interface.
- Sweeps 640x480@60 Hz VGA timing and presents each pixel coordinate on addr, packed as addr[18:9]=x and addr[8:0]=y.
- Samples the returned 3/3/3-bit colour, blanks it outside the active area, and drives the board's VGA DAC plus hs/vs.
- Emits a frame_start pulse so the sprite-update logic can align its position writes to frame boundaries.

Parameters:
- CLK_DIV, 2: system clocks per pixel (50 MHz clk -> 25 MHz pixel rate); must be >=1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- addr  out  20  pixel address: [19]=0, [18:9]=x, [8:0]=y.
- ired  in  3  red from graphics memory for the current addr (combinational return).
- igreen  in  3  green, same timing as ired.
- iblue  in  3  blue, same timing as ired.
- ored  out  3  registered red to the DAC.
- ogreen  out  3  registered green to the DAC.
- oblue  out  3  registered blue to the DAC.
- hs  out  1  horizontal sync, active low.
- vs  out  1  vertical sync, active low.
- frame_start  out  1  one-clk pulse at the frame wrap.

Behaviour:
- Reset (async assert, sync release): div_cnt=0, h_cnt=0, v_cnt=0; ored/ogreen/oblue=0; hs=1; vs=1; frame_start=0; addr=0.
- Pixel enable pe:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pe=1 in the clk where div_cnt==CLK_DIV-1.
  - When CLK_DIV=1, pe is constant 1.
- Counters (advance only on pe):
  - H_TOTAL=800, V_TOTAL=525, both derived from the parameters.
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - On the h_cnt wrap, v_cnt increments; it wraps 0 after V_TOTAL-1.
- active = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
- addr:
  - Combinational decode of the counter registers: {1'b0, h_cnt[9:0], v_cnt[8:0]} when active, else 20'h0.
  - Stable for a full pixel period (CLK_DIV clocks) before sampling.
- Output stage, registered on pe only, using the same counter values that formed addr:
  - colour = active ? {ired,igreen,iblue} : 0.
  - hs = ~(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)).
  - vs = ~(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)).
  - Latency: colour/hs/vs appear exactly 1 pixel period after their addr; all three stay mutually aligned.
- frame_start:
  - 1 for exactly one clk, in the clk where pe=1 and h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1; 0 otherwise.
  - First frame after reset has no preceding pulse.
- Input colour is ignored during blanking, even if nonzero.
- Reset mid-line: all state returns to reset values immediately; the next line starts at h=0,v=0 with no partial sync pulse retained.
- Arithmetic: h_cnt 10 bits, v_cnt 10 bits internally; only v_cnt[8:0] goes on addr (valid since V_ACTIVE<=512).

Optional Feature:
- Macro: VGA_SCANNER_BORDER_EN.
- Defined:
  - Active pixels with x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 output 3'b111 on all channels, overriding the inputs.
  - Used for monitor alignment.
- Undefined: no override; the input colour passes through unchanged on every active pixel.

Decomposition:
- Shared package/header vga_timing_pkg holds:
  - the eight timing constants;
  - derived H_TOTAL/V_TOTAL;
  - colour width (3);
  - addr field offsets (X_LSB=9, Y_LSB=0).
- One natural sub-module, vga_pixel_counter: div_cnt, pe, h_cnt, v_cnt, active, frame-wrap.
- The top level adds the addr decode, output registers and the optional border.

Test Plan:
- Reset then release, CLK_DIV=2, constant input colour 3'b101 -> addr=0 at first pe; ored=3'b101 appears at the second pe (1-pixel latency); hs=vs=1 until sync windows.
- Run one full line -> hs low for exactly 96 pixel periods (192 clk), starting 1 pixel after h_cnt=656; addr x reaches 639 then addr=0 during h 640..799.
- Run one full frame (800*525*2=840000 clk) -> exactly one frame_start pulse of 1 clk; vs low for 2 lines (1600 pixel periods), starting 1 pixel after v_cnt=490.
- Input colour forced 3'b111 throughout -> ored/ogreen/oblue=0 for all blanking pixels; 3'b111 only for the 640x480 active pixels (count 307200 per frame).
- Assert rst low mid-line at h_cnt=300, v_cnt=100 -> all outputs reach reset values without waiting for a clk edge; after release, counting restarts at h=0, v=0.
- With VGA_SCANNER_BORDER_EN and input 3'b000 -> pixels (0,0), (639,479), (320,0), (0,240) output 3'b111; (1,1) outputs 3'b000.
